// File: rtl/kb_link_pkg.sv
// kb_link_pkg: shared types and constants for the dual Manchester link arbiter.
// Holds the arbiter state encoding, the comm_state bit positions and the
// per-channel error counter width.
package kb_link_pkg;

    localparam int ERR_CNT_W = 4;
    localparam int COMM_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        FAULT = 2'd3
    } linkState_t;

    localparam int CS_STATE_HI   = 15;
    localparam int CS_STATE_LO   = 14;
    localparam int CS_SEL_B      = 13;
    localparam int CS_LINK_FAULT = 12;
    localparam int CS_ERRA_HI    = 11;
    localparam int CS_ERRA_LO    = 8;
    localparam int CS_ERRB_HI    = 7;
    localparam int CS_ERRB_LO    = 4;
    localparam int CS_TIMEOUT_A  = 3;
    localparam int CS_TIMEOUT_B  = 2;
    localparam int CS_SEEN_A     = 1;
    localparam int CS_SEEN_B     = 0;

endpackage

// File: rtl/kb_link_arbiter_if.sv
// kb_link_arbiter_if: receiver/transmitter/DSP-facing signal bundle of the
// link arbiter. The master side drives the frame pulses and control inputs,
// the slave side (the arbiter) drives the selection and status outputs.
interface kb_link_arbiter_if;
    import kb_link_pkg::*;

    logic              frame_ok_a;
    logic              frame_ok_b;
    logic              frame_err_a;
    logic              frame_err_b;
    logic              tx_en;
    logic              fault_clr;
    logic              sel_b;
    logic              rdint_sel;
    logic              tx_fs;
    logic              link_fault;
    logic [7:0]        switch_cnt;
    logic [COMM_W-1:0] comm_state;

    modport master (
        output frame_ok_a, frame_ok_b, frame_err_a, frame_err_b, tx_en, fault_clr,
        input  sel_b, rdint_sel, tx_fs, link_fault, switch_cnt, comm_state
    );

    modport slave (
        input  frame_ok_a, frame_ok_b, frame_err_a, frame_err_b, tx_en, fault_clr,
        output sel_b, rdint_sel, tx_fs, link_fault, switch_cnt, comm_state
    );

endinterface

// File: rtl/kb_chan_health.sv
// kb_chan_health: health tracker for one link channel. A watchdog counts
// cycles since the last good frame, an error counter counts consecutive bad
// frames, and a seen flag records that the channel has ever delivered a good
// frame since reset or the last return to IDLE. An error in the same cycle as
// a good frame wins: the error is counted and the watchdog keeps running.
module kb_chan_health
    import kb_link_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int ERR_LIMIT   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 frameOk,
    input  logic                 frameErr,
    output logic                 healthy,
    output logic                 timeout,
    output logic [ERR_CNT_W-1:0] errCnt,
    output logic                 seen
);

    localparam int                   WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_LIM = ERR_CNT_W'(ERR_LIMIT);

    logic [WD_W-1:0] wdCnt;

    // Watchdog: restart on a clean good frame, otherwise count up and stick at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdCnt <= '0;
        else if (frameOk && !frameErr)
            wdCnt <= '0;
        else if (wdCnt != WD_MAX)
            wdCnt <= wdCnt + WD_W'(1);
    end

    // Consecutive error count: saturating increment on error, cleared by a clean good frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            errCnt <= '0;
        else if (frameErr) begin
            if (errCnt != ERR_MAX)
                errCnt <= errCnt + ERR_CNT_W'(1);
        end
        else if (frameOk)
            errCnt <= '0;
    end

    // Seen flag: latched by the first good frame, dropped when the arbiter re-enters IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seen <= 1'b0;
        else if (clr)
            seen <= 1'b0;
        else if (frameOk)
            seen <= 1'b1;
    end

    assign timeout = (wdCnt == WD_MAX);
    assign healthy = seen && !timeout && (errCnt < ERR_LIM);

endmodule

// File: rtl/kb_link_arbiter.sv
// kb_link_arbiter: redundancy arbiter and transmit scheduler for the dual
// Manchester link. Tracks health of channels A and B, selects the active
// channel, flags a link fault when both are lost and produces the periodic
// transmit frame strobe.
// Optional feature macro: KB_REVERT_A_EN -- while B is active, a run of
// REVERT_FRAMES consecutive good A frames switches back to A.
module kb_link_arbiter
    import kb_link_pkg::*;
#(
    parameter int TIMEOUT_CYC   = 100000,
    parameter int ERR_LIMIT     = 3,
`ifdef KB_REVERT_A_EN
    parameter int REVERT_FRAMES = 8,
`endif
    parameter int TX_PERIOD     = 10000
) (
    input  logic               clk_100M,
    input  logic               reset,
    kb_link_arbiter_if.slave   bus
);

    localparam int             TX_W    = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_PERIOD - 1);

    linkState_t           state;
    linkState_t           nextState;
    logic                 doSwitch;
    logic                 chanClr;
    logic                 revertReq;
    logic                 healthyA, healthyB;
    logic                 timeoutA, timeoutB;
    logic                 seenA, seenB;
    logic [ERR_CNT_W-1:0] errCntA, errCntB;
    logic [TX_W-1:0]      txCnt;
    logic [COMM_W-1:0]    commWord;

    assign chanClr = (nextState == IDLE) && (state != IDLE);

    kb_chan_health #(.TIMEOUT_CYC(TIMEOUT_CYC), .ERR_LIMIT(ERR_LIMIT)) healthA (
        .clk(clk_100M), .reset(reset), .clr(chanClr),
        .frameOk(bus.frame_ok_a), .frameErr(bus.frame_err_a),
        .healthy(healthyA), .timeout(timeoutA), .errCnt(errCntA), .seen(seenA)
    );

    kb_chan_health #(.TIMEOUT_CYC(TIMEOUT_CYC), .ERR_LIMIT(ERR_LIMIT)) healthB (
        .clk(clk_100M), .reset(reset), .clr(chanClr),
        .frameOk(bus.frame_ok_b), .frameErr(bus.frame_err_b),
        .healthy(healthyB), .timeout(timeoutB), .errCnt(errCntB), .seen(seenB)
    );

`ifdef KB_REVERT_A_EN
    localparam int              REV_W   = $clog2(REVERT_FRAMES + 1);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(REVERT_FRAMES);

    logic [REV_W-1:0] revCnt;

    // Run length of clean A frames while B is active; any A trouble restarts the run
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset)
            revCnt <= '0;
        else if (state != RUN_B || bus.frame_err_a || timeoutA)
            revCnt <= '0;
        else if (bus.frame_ok_a && revCnt != REV_MAX)
            revCnt <= revCnt + REV_W'(1);
    end

    assign revertReq = (revCnt == REV_MAX);
`else
    assign revertReq = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state selection: A preferred, switchovers counted, FAULT held until cleared
    always_comb begin
        nextState = state;
        doSwitch  = 1'b0;
        case (state)
            IDLE: begin
                if (healthyA)
                    nextState = RUN_A;
                else if (healthyB)
                    nextState = RUN_B;
            end
            RUN_A: begin
                if (!healthyA && healthyB) begin
                    nextState = RUN_B;
                    doSwitch  = 1'b1;
                end
                else if (!healthyA && !healthyB)
                    nextState = FAULT;
            end
            RUN_B: begin
                if (!healthyB && healthyA) begin
                    nextState = RUN_A;
                    doSwitch  = 1'b1;
                end
                else if (!healthyB && !healthyA)
                    nextState = FAULT;
                else if (revertReq && healthyA) begin
                    nextState = RUN_A;
                    doSwitch  = 1'b1;
                end
            end
            FAULT: begin
                if (bus.fault_clr)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Channel select and fault flag registered alongside the state
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            bus.sel_b      <= 1'b0;
            bus.link_fault <= 1'b0;
        end
        else begin
            bus.sel_b      <= (nextState == RUN_B);
            bus.link_fault <= (nextState == FAULT);
        end
    end

    // Saturating switchover counter
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset)
            bus.switch_cnt <= '0;
        else if (doSwitch && bus.switch_cnt != 8'hFF)
            bus.switch_cnt <= bus.switch_cnt + 8'd1;
    end

    // Read interrupt: clean good frame on the channel active before this edge
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset)
            bus.rdint_sel <= 1'b0;
        else begin
            case (state)
                RUN_A:   bus.rdint_sel <= bus.frame_ok_a && !bus.frame_err_a;
                RUN_B:   bus.rdint_sel <= bus.frame_ok_b && !bus.frame_err_b;
                default: bus.rdint_sel <= 1'b0;
            endcase
        end
    end

    // Transmit scheduler: strobe at count 0, counter parked at 0 while disabled
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            txCnt     <= '0;
            bus.tx_fs <= 1'b0;
        end
        else if (!bus.tx_en) begin
            txCnt     <= '0;
            bus.tx_fs <= 1'b0;
        end
        else begin
            bus.tx_fs <= (txCnt == '0);
            txCnt     <= (txCnt == TX_LAST) ? '0 : txCnt + TX_W'(1);
        end
    end

    // Status word assembled from registered state and channel trackers
    always_comb begin
        commWord                            = '0;
        commWord[CS_STATE_HI:CS_STATE_LO]   = state;
        commWord[CS_SEL_B]                  = (state == RUN_B);
        commWord[CS_LINK_FAULT]             = (state == FAULT);
        commWord[CS_ERRA_HI:CS_ERRA_LO]     = errCntA;
        commWord[CS_ERRB_HI:CS_ERRB_LO]     = errCntB;
        commWord[CS_TIMEOUT_A]              = timeoutA;
        commWord[CS_TIMEOUT_B]              = timeoutB;
        commWord[CS_SEEN_A]                 = seenA;
        commWord[CS_SEEN_B]                 = seenB;
    end

    assign bus.comm_state = commWord;

endmodule

// File: tb/tb_kb_link_arbiter.sv
// tb_kb_link_arbiter: directed self-checking bench for kb_link_arbiter with a
// short watchdog (50 cycles) and TX_PERIOD = 10. Covers reset, channel
// selection, error and timeout switchover, FAULT hold/clear, the transmit
// strobe, asynchronous reset and the optional revert-to-A behaviour
// (KB_REVERT_A_EN).
module tb_kb_link_arbiter;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;
    int   n;

    kb_link_arbiter_if bus();

    kb_link_arbiter #(
        .TIMEOUT_CYC(50),
        .ERR_LIMIT(3),
        .TX_PERIOD(10)
    ) dut (
        .clk_100M(clk),
        .reset(reset),
        .bus(bus)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of input pulses, then return all pulses low
    task automatic applyStimulus(input logic okA, input logic errA,
                                 input logic okB, input logic errB,
                                 input logic clr);
        bus.frame_ok_a  = okA;
        bus.frame_err_a = errA;
        bus.frame_ok_b  = okB;
        bus.frame_err_b = errB;
        bus.fault_clr   = clr;
        tick();
        bus.frame_ok_a  = 1'b0;
        bus.frame_err_a = 1'b0;
        bus.frame_ok_b  = 1'b0;
        bus.frame_err_b = 1'b0;
        bus.fault_clr   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount      = 0;
        errorCount      = 0;
        reset           = 1'b1;
        bus.frame_ok_a  = 1'b0;
        bus.frame_err_a = 1'b0;
        bus.frame_ok_b  = 1'b0;
        bus.frame_err_b = 1'b0;
        bus.fault_clr   = 1'b0;
        bus.tx_en       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_comm",   bus.comm_state, 16'h0000);
        checkOutput("rst_sel",    16'(bus.sel_b), 16'h0);
        checkOutput("rst_fault",  16'(bus.link_fault), 16'h0);
        checkOutput("rst_swcnt",  16'(bus.switch_cnt), 16'h0);
        checkOutput("rst_rdint",  16'(bus.rdint_sel), 16'h0);
        checkOutput("rst_txfs",   16'(bus.tx_fs), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // First frames on both channels: seen set, still IDLE, then RUN_A
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("seen_idle",  bus.comm_state, 16'h0003);
        checkOutput("rdint_idle", 16'(bus.rdint_sel), 16'h0);
        tick();
        checkOutput("run_a",      bus.comm_state, 16'h4003);
        checkOutput("run_a_sel",  16'(bus.sel_b), 16'h0);

        // rdint follows active-channel frames only
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rdint_a",    16'(bus.rdint_sel), 16'h1);
        tick();
        checkOutput("rdint_a_off", 16'(bus.rdint_sel), 16'h0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rdint_b_in_a", 16'(bus.rdint_sel), 16'h0);

        // Three A errors, the first coinciding with a good frame
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("okerr_rdint", 16'(bus.rdint_sel), 16'h0);
        checkOutput("err1_cnt",    16'(bus.comm_state[11:8]), 16'h1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("err3_state",  bus.comm_state, 16'h4303);
        tick();
        checkOutput("err_sw_comm", bus.comm_state, 16'hA303);
        checkOutput("err_sw_sel",  16'(bus.sel_b), 16'h1);
        checkOutput("err_sw_cnt",  16'(bus.switch_cnt), 16'h1);

        // rdint in RUN_B
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rdint_a_in_b", 16'(bus.rdint_sel), 16'h0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rdint_b",      16'(bus.rdint_sel), 16'h1);

        // B goes silent while A keeps going: switch 51 cycles after the last B frame
        n = 0;
        while (bus.sel_b && n < 80) begin
            applyStimulus((n % 10) == 0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("to_latency", 16'(n), 16'd51);
        checkOutput("to_sel",     16'(bus.sel_b), 16'h0);
        checkOutput("to_swcnt",   16'(bus.switch_cnt), 16'h2);
        checkOutput("to_b_flag",  16'(bus.comm_state[2]), 16'h1);

        // Both silent: FAULT
        n = 0;
        while (!bus.link_fault && n < 100) begin
            tick();
            n++;
        end
        checkOutput("fault_flag",  16'(bus.link_fault), 16'h1);
        checkOutput("fault_state", 16'(bus.comm_state[15:14]), 16'h3);
        checkOutput("fault_swcnt", 16'(bus.switch_cnt), 16'h2);

        // A recovers without fault_clr: FAULT held
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) tick();
        checkOutput("fault_hold",  16'(bus.comm_state[15:14]), 16'h3);

        // fault_clr: IDLE with seen flags dropped, then RUN_A after next A frame
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("clr_idle",    bus.comm_state, 16'h0004);
        checkOutput("clr_fault",   16'(bus.link_fault), 16'h0);
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        checkOutput("clr_run_a",   bus.comm_state, 16'h4006);

        // Transmit strobe at +1, +11, +21 after tx_en rises; silent after it drops
        bus.tx_en = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            checkOutput($sformatf("txfs_%0d", i), 16'(bus.tx_fs),
                        16'((i == 1) || (i == 11) || (i == 21)));
        end
        bus.tx_en = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checkOutput($sformatf("txfs_off_%0d", i), 16'(bus.tx_fs), 16'h0);
        end

        // Asynchronous reset between edges clears everything at once
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_comm",  bus.comm_state, 16'h0000);
        checkOutput("arst_swcnt", 16'(bus.switch_cnt), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Only B seen: IDLE -> RUN_B is not a switchover
        applyStimulus(0, 0, 1, 0, 0);
        tick();
        checkOutput("b_only_comm",  bus.comm_state, 16'hA001);
        checkOutput("b_only_swcnt", 16'(bus.switch_cnt), 16'h0);

        // Seven A frames, an A error, seven more: B stays active
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            tick();
        end
        checkOutput("rev7_sel", 16'(bus.sel_b), 16'h1);

        // Eighth consecutive A frame
        applyStimulus(1, 0, 0, 0, 0);
        tick();
`ifdef KB_REVERT_A_EN
        checkOutput("rev8_sel",   16'(bus.sel_b), 16'h0);
        checkOutput("rev8_swcnt", 16'(bus.switch_cnt), 16'h1);
`else
        checkOutput("norev_sel",   16'(bus.sel_b), 16'h1);
        checkOutput("norev_swcnt", 16'(bus.switch_cnt), 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
